data_mem_responder: RTL and testbench

Memory-side responder for the CPU's data port. It accepts one load or store request at a time through a valid/ready handshake and stalls for a programmable number of wait states. It then performs the access on an internal doubleword array and returns a held response until the initiator takes it. It is the slave end of the data-memory interface, and it is what lets the core move from an ideal single-cycle memory to multi-cycle timing.

---
 rtl/data_mem_responder_pkg.sv | 16 +
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder_array.sv | 33 +++
 rtl/data_mem_responder.sv | 122 ++++++++++++
 tb/tb_data_mem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM state
// encoding, doubleword geometry and wait-counter width.
package data_mem_pkg;

    localparam int DWORD_BYTES = 8;
    localparam int OFFSET_BITS = 3;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the CPU data port (master) and the
// memory responder (slave).
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/data_mem_responder_array.sv
// DEPTH x 64-bit doubleword storage: synchronous write port and a read
// register that only updates on a read strobe, so it holds across RESP.
module data_mem_array #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [63:0]              wdata,
    output logic [63:0]              rdata
);

    logic [63:0] mem [DEPTH];
    logic [63:0] rdata_q;
    logic [63:0] rdata_d;

    always_comb begin
        rdata_d = rd_en ? mem[idx] : rdata_q;
    end

    // NOTE: storage and its read register carry no reset; contents must
    // survive reset, and the owner masks the read data until a valid load.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one request at a time, LATENCY wait
// states, held response. Optional alignment check: DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam int                IDX_W      = $clog2(DEPTH);
    localparam logic [63:0]       ADDR_LIMIT = 64'(DEPTH) * 64'(DWORD_BYTES);
    localparam logic [CNT_W-1:0]  WAIT_INIT  = CNT_W'(LATENCY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;
    logic             rd_ok_q, rd_ok_d;
    logic             write_q, write_d;
    logic [63:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;

    logic             access_err;
    logic             mem_wr_en;
    logic             mem_rd_en;
    logic [63:0]      arr_rdata;

    always_comb begin
        access_err = (addr_q >= ADDR_LIMIT);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        access_err = access_err || (addr_q[OFFSET_BITS-1:0] != '0);
`endif
    end

    // A reset landing on the ACCESS edge aborts the store as well.
    assign mem_wr_en = (state_q == ACCESS) && write_q && !access_err && !reset;
    assign mem_rd_en = (state_q == ACCESS) && !write_q && !access_err;

    data_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .wr_en (mem_wr_en),
        .rd_en (mem_rd_en),
        .idx   (addr_q[OFFSET_BITS +: IDX_W]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // NOTE: every always_comb output is defaulted to its held value first,
    // so no path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        rd_ok_d = rd_ok_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = (LATENCY > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                error_d = access_err;
                rd_ok_d = !write_q && !access_err;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    error_d = 1'b0;
                    rd_ok_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            error_q <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            rd_ok_q <= rd_ok_d;
        end
    end

    // Request capture registers are only consumed after a fresh capture.
    always_ff @(posedge clk) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rd_ok_q ? arr_rdata : '0;
    assign bus.rsp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (LATENCY 2 and 0) behind one shared
// stimulus port, checked against an array model of the memory contract.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_error;

    logic [63:0] model_mem [2][DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if if_a ();
    data_mem_responder_if if_b ();

    assign if_a.req_valid = req_valid & ~sel;
    assign if_b.req_valid = req_valid & sel;
    assign if_a.rsp_ready = rsp_ready & ~sel;
    assign if_b.rsp_ready = rsp_ready & sel;
    assign if_a.req_write = req_write;
    assign if_b.req_write = req_write;
    assign if_a.req_addr  = req_addr;
    assign if_b.req_addr  = req_addr;
    assign if_a.req_wdata = req_wdata;
    assign if_b.req_wdata = req_wdata;

    assign req_ready = sel ? if_b.req_ready : if_a.req_ready;
    assign rsp_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
    assign rsp_rdata = sel ? if_b.rsp_rdata : if_a.rsp_rdata;
    assign rsp_error = sel ? if_b.rsp_error : if_a.rsp_error;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    function automatic bit exp_err(input logic [63:0] a);
        return (a >= 64'(DEPTH * 8)) || (ALIGN && (a[2:0] != 3'b000));
    endfunction

    // One complete transaction on the selected DUT; starts and ends on a negedge.
    // Response cycle: the cycle after the acceptance edge is cycle 1.
    task automatic do_txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input int stall);
        logic [63:0] exp_rd;
        logic [63:0] rd0;
        bit          exp_e;
        logic        e0;
        int          s, idx, acc, n, lat, exp_lat;
        s       = int'(sel);
        idx     = int'(a[10:3]);
        exp_e   = exp_err(a);
        exp_lat = (s == 1) ? LAT_B + 2 : LAT_A + 2;
        if (w) begin
            exp_rd = '0;
            if (!exp_e) model_mem[s][idx] = d;
        end else begin
            exp_rd = exp_e ? 64'd0 : model_mem[s][idx];
        end

        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout addr=%h req_ready=%b required=1", a, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        acc = cyc;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};

        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rsp_timeout addr=%h rsp_valid=%b required=1", a, rsp_valid);
            return;
        end
        lat = cyc - acc + 1;
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL latency sel=%0d addr=%h got=%0d required=%0d", s, a, lat, exp_lat);
        end
        checks++;
        if (rsp_rdata !== exp_rd) begin
            failures++;
            $display("FAIL rdata sel=%0d w=%b addr=%h got=%h required=%h", s, w, a, rsp_rdata, exp_rd);
        end
        checks++;
        if (rsp_error !== exp_e) begin
            failures++;
            $display("FAIL error sel=%0d w=%b addr=%h got=%b required=%b", s, w, a, rsp_error, exp_e);
        end

        rd0 = rsp_rdata;
        e0  = rsp_error;
        for (int k = 0; k < stall; k++) begin
            req_valid = 1'($urandom);
            req_write = 1'b1;
            req_addr  = 64'($urandom_range(0, DEPTH - 1)) << 3;
            req_wdata = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || rsp_error !== e0 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold k=%0d valid=%b rdata=%h err=%b req_ready=%b required 1/%h/%b/0",
                         k, rsp_valid, rsp_rdata, rsp_error, req_ready, rd0, e0);
            end
        end
        req_valid = 1'b0;

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL release req_ready=%b rsp_valid=%b required 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (if_a.req_ready !== 1'b1 || if_a.rsp_valid !== 1'b0 ||
            if_a.rsp_rdata !== 64'd0 || if_a.rsp_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_a ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                     if_a.req_ready, if_a.rsp_valid, if_a.rsp_rdata, if_a.rsp_error);
        end
        checks++;
        if (if_b.req_ready !== 1'b1 || if_b.rsp_valid !== 1'b0 ||
            if_b.rsp_rdata !== 64'd0 || if_b.rsp_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_b ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                     if_b.req_ready, if_b.rsp_valid, if_b.rsp_rdata, if_b.rsp_error);
        end
    endtask

    task automatic test_fill();
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int i = 0; i < DEPTH; i++) begin
                do_txn(1'b1, 64'(i) << 3, {$urandom, $urandom}, 0);
            end
        end
    endtask

    task automatic test_store_load();
        sel = 1'b0;
        do_txn(1'b1, 64'h10, 64'hDEADBEEF_01234567, 0);
        do_txn(1'b0, 64'h10, 64'd0, 0);
        checks++;
        if (model_mem[0][2] !== 64'hDEADBEEF_01234567) begin
            failures++;
            $display("FAIL model_store got=%h required=%h", model_mem[0][2], 64'hDEADBEEF_01234567);
        end
    endtask

    task automatic test_back_to_back();
        int          acc [2];
        int          rv  [2];
        logic [63:0] rd  [2];
        int          na, nr;
        na = 0; nr = 0;
        sel = 1'b1;
        req_write = 1'b0; req_addr = 64'h0; req_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (req_valid && req_ready && na < 2) begin acc[na] = cyc + 1; na++; end
            if (rsp_valid && nr < 2) begin rv[nr] = cyc; rd[nr] = rsp_rdata; nr++; end
            @(negedge clk);
            if (na == 1) req_addr = 64'h8;
            if (na == 2) req_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (na != 2 || nr != 2) begin
            failures++;
            $display("FAIL b2b_count accepts=%0d responses=%0d required 2/2", na, nr);
            return;
        end
        checks++;
        if (acc[1] - acc[0] != 3) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d required=3", acc[1] - acc[0]);
        end
        checks++;
        if (rv[0] - acc[0] + 1 != 2 || rv[1] - acc[1] + 1 != 2) begin
            failures++;
            $display("FAIL b2b_latency got=%0d,%0d required=2,2", rv[0] - acc[0] + 1, rv[1] - acc[1] + 1);
        end
        checks++;
        if (rd[0] !== model_mem[1][0] || rd[1] !== model_mem[1][1]) begin
            failures++;
            $display("FAIL b2b_rdata got=%h,%h required=%h,%h", rd[0], rd[1], model_mem[1][0], model_mem[1][1]);
        end
    endtask

    task automatic test_out_of_range();
        sel = 1'b0;
        do_txn(1'b1, 64'h800, {$urandom, $urandom}, 0);
        do_txn(1'b0, 64'h800, 64'd0, 0);
        do_txn(1'b1, 64'h8000_0000_0000_0010, {$urandom, $urandom}, 0);
        do_txn(1'b1, 64'h0000_0001_0000_0000, {$urandom, $urandom}, 0);
        do_txn(1'b0, 64'h0, 64'd0, 0);
        do_txn(1'b0, 64'h7F8, 64'd0, 0);
        do_txn(1'b0, 64'h10, 64'd0, 0);
    endtask

    task automatic test_misaligned();
        sel = 1'b0;
        do_txn(1'b1, 64'h13, {$urandom, $urandom}, 0);
        do_txn(1'b0, 64'h10, 64'd0, 0);
        do_txn(1'b0, 64'h13, 64'd0, 0);
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        do_txn(1'b0, 64'h10, 64'd0, 10);
        do_txn(1'b1, 64'h20, {$urandom, $urandom}, 10);
        do_txn(1'b0, 64'h20, 64'd0, 0);
        sel = 1'b1;
        do_txn(1'b0, 64'h8, 64'd0, 10);
    endtask

    task automatic test_reset_mid_store();
        int n;
        sel = 1'b0;
        req_write = 1'b1; req_addr = 64'h18; req_wdata = {$urandom, $urandom}; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_store req_ready=%b rsp_valid=%b rsp_error=%b required 1/0/0",
                     req_ready, rsp_valid, rsp_error);
        end
        do_txn(1'b0, 64'h18, 64'd0, 0);
    endtask

    task automatic test_random();
        logic [63:0] a;
        int          kind;
        for (int i = 0; i < 150; i++) begin
            sel  = 1'($urandom);
            kind = $urandom_range(0, 7);
            case (kind)
                5:       a = (64'($urandom_range(0, DEPTH - 1)) << 3) | 64'($urandom_range(1, 7));
                6:       a = {$urandom, $urandom} | 64'h800;
                7:       a = ($urandom_range(0, 1) == 1) ? 64'h7F8 : 64'h800;
                default: a = 64'($urandom_range(0, DEPTH - 1)) << 3;
            endcase
            do_txn(1'($urandom), a, {$urandom, $urandom}, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_back_to_back();
        test_out_of_range();
        test_misaligned();
        test_backpressure();
        test_reset_mid_store();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycles=%0d required_finish_before=200000", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
